amm_transaction_driver: RTL and testbench
=========================================

// Module: amm_transaction_driver
// PURPOSE
// - Responder end of the operation-descriptor handshake from the test control logic: accepts one descriptor at a time.
// - Turns each descriptor into an Avalon-MM master burst (write or read), with byteenables built from the start/end byte offsets.
// - Sits between the control block and the memory under test; read data is checked downstream, not here.
// PARAMETERS
// AMM_DATA_W    128                       Avalon data width, bits
// AMM_ADDR_W    12                        Avalon byte address width
// AMM_BURST_W   11                        Avalon burstcount width
// BYTE_PER_WORD AMM_DATA_W/8              bytes per data word
// BYTE_ADDR_W   $clog2(BYTE_PER_WORD)     byte-offset width
// ADDR_W        AMM_ADDR_W-BYTE_ADDR_W    word address width
// PORTS
// clk_i                  in   1              single clock
// rst_i                  in   1              synchronous, active-high reset
// op_valid_i             in   1              descriptor valid
// op_ready_o             out  1              descriptor accepted when valid && ready
// op_type_i              in   1              0 = write, 1 = read
// op_word_addr_i         in   ADDR_W         first word address
// op_word_burst_count_i  in   AMM_BURST_W    burst length N in words
// op_start_offset_i      in   BYTE_ADDR_W    first valid byte in the first word
// op_end_offset_i        in   BYTE_ADDR_W    last valid byte in the last word
// data_pattern_i         in   8              write byte pattern
// amm_address_o          out  AMM_ADDR_W     {word_addr, BYTE_ADDR_W'b0}
// amm_write_o            out  1              Avalon write
// amm_read_o             out  1              Avalon read
// amm_writedata_o        out  AMM_DATA_W     {BYTE_PER_WORD{pattern}}
// amm_byteenable_o       out  BYTE_PER_WORD  byte enables
// amm_burstcount_o       out  AMM_BURST_W    N
// amm_waitrequest_i      in   1              slave stall
// wr_burst_cnt_o         out  32             completed write bursts, saturating
// rd_burst_cnt_o         out  32             accepted read commands, saturating
// BEHAVIOUR
// - Reset: FSM -> IDLE; every amm_* output, both counters and the internal beat counter -> 0; op_ready_o -> 1 in the first cycle after reset.
//   A reset mid-burst abandons the burst immediately; no further beats are issued.
// - FSM IDLE / WRITE_BURST / READ_CMD; op_ready_o = (state==IDLE); op_valid_i is ignored outside IDLE.
// - IDLE accept at edge T: latch all descriptor fields and data_pattern_i.
//   A descriptor with N=0 is treated as N=1.
//   Next state is WRITE_BURST or READ_CMD; amm_write_o or amm_read_o is high from cycle T+1.
// - Address/burstcount: driven from the latched values, constant for the whole burst.
// - WRITE_BURST: amm_write_o held high.
//   A beat completes on a cycle where amm_write_o && !amm_waitrequest_i; the beat index b then increments.
//   Byteenable bit i for beat b:
//     b==0 && N==1: (i>=start) & (i<=end)
//     b==0:         i>=start
//     b==N-1:       i<=end
//     otherwise:    1
//   Byteenable and writedata stay stable while waitrequest is high.
//   On the edge completing beat N-1: amm_write_o -> 0, wr_burst_cnt_o += 1, state -> IDLE.
// - READ_CMD: amm_read_o high with amm_byteenable_o all ones, held until !amm_waitrequest_i.
//   On that edge: amm_read_o -> 0, rd_burst_cnt_o += 1, state -> IDLE.
// - Throughput: at least one IDLE cycle between operations. A descriptor held valid is accepted on the first cycle op_ready_o is 1.
// - Counters saturate at 32'hFFFF_FFFF and do not wrap.
// - In IDLE, amm_write_o = amm_read_o = 0; address, burstcount, byteenable and writedata hold their last values.
// - Widths: beat counter is AMM_BURST_W bits; offset compares are unsigned.
//   end < start with N==1 gives byteenable 0; the beat is still issued.
// TESTING (defaults, BYTE_PER_WORD=16)
// 1) Write, addr 0x12, N=1, start 3, end 5, pattern 0xA5 -> one beat: address 0x120, burstcount 1, byteenable 0x0038, writedata all 0xA5; wr_burst_cnt_o = 1.
// 2) Write N=3, start 4, end 1, waitrequest high 2 cycles on beat 1 -> byteenable 0xFFF0, then 0xFFFF held 3 cycles, then 0x0003; amm_write_o high 5 cycles total.
// 3) Read addr 0x40, N=4, waitrequest high 3 cycles -> amm_read_o high 4 cycles, address 0x400, burstcount 4; op_ready_o returns 1 the next cycle; rd_burst_cnt_o = 1.
// 4) op_valid_i held high through two write descriptors -> second accepted exactly 1 cycle after the first burst ends; fields not corrupted by input changes mid-burst.
// 5) rst_i asserted on beat 2 of an N=8 write -> amm_write_o = 0 next cycle, counters 0, op_ready_o = 1; no further beats.
// 6) N=0 write descriptor -> single beat with burstcount 1, byteenable per the N==1 rule.

Source files
------------

// File: rtl/amm_transaction_driver.sv
// amm_transaction_driver: turns one accepted operation descriptor into an Avalon-MM write burst or read command
module amm_transaction_driver #(
  parameter int AMM_DATA_W = 128,
  parameter int AMM_ADDR_W = 12,
  parameter int AMM_BURST_W = 11,
  localparam int BYTE_PER_WORD = AMM_DATA_W / 8,
  localparam int BYTE_ADDR_W = $clog2(BYTE_PER_WORD),
  localparam int ADDR_W = AMM_ADDR_W - BYTE_ADDR_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     op_valid_i,
  output logic                     op_ready_o,
  input  logic                     op_type_i,
  input  logic [ADDR_W-1:0]        op_word_addr_i,
  input  logic [AMM_BURST_W-1:0]   op_word_burst_count_i,
  input  logic [BYTE_ADDR_W-1:0]   op_start_offset_i,
  input  logic [BYTE_ADDR_W-1:0]   op_end_offset_i,
  input  logic [7:0]               data_pattern_i,
  output logic [AMM_ADDR_W-1:0]    amm_address_o,
  output logic                     amm_write_o,
  output logic                     amm_read_o,
  output logic [AMM_DATA_W-1:0]    amm_writedata_o,
  output logic [BYTE_PER_WORD-1:0] amm_byteenable_o,
  output logic [AMM_BURST_W-1:0]   amm_burstcount_o,
  input  logic                     amm_waitrequest_i,
  output logic [31:0]              wr_burst_cnt_o,
  output logic [31:0]              rd_burst_cnt_o
);
  typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_CMD} state_t;
  state_t state;
  logic [AMM_BURST_W-1:0] beat, n_q, n_in;
  logic [BYTE_ADDR_W-1:0] s_q, e_q;
  function automatic logic [BYTE_PER_WORD-1:0] be_of(
    input logic [AMM_BURST_W-1:0] b, n,
    input logic [BYTE_ADDR_W-1:0] s, e
  );
    logic [BYTE_PER_WORD-1:0] m;
    for (int i = 0; i < BYTE_PER_WORD; i++)
      m[i] = (b == '0 && n == AMM_BURST_W'(1)) ? (i >= int'(s) && i <= int'(e)) :
             b == '0 ? i >= int'(s) :
             b == n - AMM_BURST_W'(1) ? i <= int'(e) : 1'b1;
    return m;
  endfunction
  assign n_in = op_word_burst_count_i == '0 ? AMM_BURST_W'(1) : op_word_burst_count_i;
  assign op_ready_o = state == IDLE;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      amm_address_o <= '0;
      amm_write_o <= 1'b0;
      amm_read_o <= 1'b0;
      amm_writedata_o <= '0;
      amm_byteenable_o <= '0;
      amm_burstcount_o <= '0;
      wr_burst_cnt_o <= '0;
      rd_burst_cnt_o <= '0;
      beat <= '0;
      n_q <= '0;
      s_q <= '0;
      e_q <= '0;
    end else
      case (state)
        IDLE: if (op_valid_i) begin
          amm_address_o <= {op_word_addr_i, BYTE_ADDR_W'(0)};
          amm_burstcount_o <= n_in;
          amm_writedata_o <= {BYTE_PER_WORD{data_pattern_i}};
          amm_byteenable_o <= op_type_i ? '1 : be_of('0, n_in, op_start_offset_i, op_end_offset_i);
          amm_write_o <= !op_type_i;
          amm_read_o <= op_type_i;
          n_q <= n_in;
          s_q <= op_start_offset_i;
          e_q <= op_end_offset_i;
          beat <= '0;
          state <= op_type_i ? READ_CMD : WRITE_BURST;
        end
        WRITE_BURST: if (!amm_waitrequest_i) begin
          if (beat == n_q - AMM_BURST_W'(1)) begin
            amm_write_o <= 1'b0;
            wr_burst_cnt_o <= &wr_burst_cnt_o ? wr_burst_cnt_o : wr_burst_cnt_o + 32'd1;
            state <= IDLE;
          end else begin
            beat <= beat + AMM_BURST_W'(1);
            amm_byteenable_o <= be_of(beat + AMM_BURST_W'(1), n_q, s_q, e_q);
          end
        end
        READ_CMD: if (!amm_waitrequest_i) begin
          amm_read_o <= 1'b0;
          rd_burst_cnt_o <= &rd_burst_cnt_o ? rd_burst_cnt_o : rd_burst_cnt_o + 32'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_amm_transaction_driver.sv
// tb_amm_transaction_driver: table vectors, directed corner sequences and random ops checked against a byte-mask model
module tb_amm_transaction_driver;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic op_valid_i = 1'b0, op_ready_o, op_type_i = 1'b0;
  logic [7:0] op_word_addr_i = '0;
  logic [10:0] op_word_burst_count_i = '0;
  logic [3:0] op_start_offset_i = '0, op_end_offset_i = '0;
  logic [7:0] data_pattern_i = '0;
  logic [11:0] amm_address_o;
  logic amm_write_o, amm_read_o, amm_waitrequest_i = 1'b0;
  logic [127:0] amm_writedata_o;
  logic [15:0] amm_byteenable_o;
  logic [10:0] amm_burstcount_o;
  logic [31:0] wr_burst_cnt_o, rd_burst_cnt_o;
  int checks = 0, failures = 0, exp_wr = 0, exp_rd = 0, dummy;
  always #5 clk_i = ~clk_i;
  amm_transaction_driver dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_type_i(op_type_i), .op_word_addr_i(op_word_addr_i),
    .op_word_burst_count_i(op_word_burst_count_i), .op_start_offset_i(op_start_offset_i),
    .op_end_offset_i(op_end_offset_i), .data_pattern_i(data_pattern_i),
    .amm_address_o(amm_address_o), .amm_write_o(amm_write_o), .amm_read_o(amm_read_o),
    .amm_writedata_o(amm_writedata_o), .amm_byteenable_o(amm_byteenable_o),
    .amm_burstcount_o(amm_burstcount_o), .amm_waitrequest_i(amm_waitrequest_i),
    .wr_burst_cnt_o(wr_burst_cnt_o), .rd_burst_cnt_o(rd_burst_cnt_o)
  );
  typedef struct {
    bit typ; logic [7:0] addr; logic [10:0] n; logic [3:0] s, e; logic [7:0] pat;
    logic [11:0] ea; logic [10:0] ebc; logic [15:0] ebe;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] model_be(input int b, input int n, input int s, input int e);
    logic [15:0] lo, hi;
    lo = 16'hFFFF << s;
    hi = 16'hFFFF >> (15 - e);
    if (n == 1) return lo & hi;
    if (b == 0) return lo;
    if (b == n - 1) return hi;
    return 16'hFFFF;
  endfunction
  task automatic step();
    @(posedge clk_i); #1;
  endtask
  task automatic wait_ready();
    int g = 0;
    while (!op_ready_o && g < 50) begin step(); g++; end
    if (!op_ready_o) chk("ready_timeout", op_ready_o, 1);
  endtask
  task automatic drive(input bit typ, input logic [7:0] addr, input logic [10:0] n,
                       input logic [3:0] s, input logic [3:0] e, input logic [7:0] pat);
    op_type_i = typ; op_word_addr_i = addr; op_word_burst_count_i = n;
    op_start_offset_i = s; op_end_offset_i = e; data_pattern_i = pat; op_valid_i = 1'b1;
  endtask
  task automatic run_op(input bit typ, input logic [7:0] addr, input logic [10:0] n,
                        input logic [3:0] s, input logic [3:0] e, input logic [7:0] pat,
                        input bit rnd, input int sb, input int sn, output int hi);
    int nn, beats, b, st, g;
    bit w;
    nn = (n == 0) ? 1 : int'(n);
    beats = typ ? 1 : nn;
    b = 0; st = 0; g = 0; hi = 0;
    wait_ready();
    drive(typ, addr, n, s, e, pat);
    step();
    op_valid_i = 1'b0;
    op_word_addr_i = 8'($urandom); op_word_burst_count_i = 11'($urandom);
    op_start_offset_i = 4'($urandom); op_end_offset_i = 4'($urandom); data_pattern_i = 8'($urandom);
    chk("op_addr", amm_address_o, {addr, 4'h0});
    chk("op_burstcount", amm_burstcount_o, 11'(nn));
    if (!typ) chk("op_wdata", amm_writedata_o, {16{pat}});
    while (b < beats && g < 200) begin
      g++;
      w = rnd ? ($urandom_range(0, 2) == 0) : (b == sb && st < sn);
      amm_waitrequest_i = w;
      chk("op_strobe", typ ? amm_read_o : amm_write_o, 1);
      chk("op_other_strobe", typ ? amm_write_o : amm_read_o, 0);
      chk("op_busy_ready", op_ready_o, 0);
      chk("op_be", amm_byteenable_o, typ ? 16'hFFFF : model_be(b, nn, int'(s), int'(e)));
      hi++;
      step();
      if (w) st++; else begin b++; st = 0; end
    end
    amm_waitrequest_i = 1'b0;
    if (g >= 200) chk("op_timeout", g, 0);
    if (typ) exp_rd++; else exp_wr++;
    chk("op_end_write", amm_write_o, 0);
    chk("op_end_read", amm_read_o, 0);
    chk("op_end_ready", op_ready_o, 1);
    chk("op_wr_cnt", wr_burst_cnt_o, 32'(exp_wr));
    chk("op_rd_cnt", rd_burst_cnt_o, 32'(exp_rd));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int hi, g;
    tbl[0] = '{0, 8'h12, 11'd1, 4'd3, 4'd5, 8'hA5, 12'h120, 11'd1, 16'h0038};
    tbl[1] = '{0, 8'h07, 11'd0, 4'd2, 4'd9, 8'h3C, 12'h070, 11'd1, 16'h03FC};
    tbl[2] = '{0, 8'h55, 11'd1, 4'd9, 4'd2, 8'h01, 12'h550, 11'd1, 16'h0000};
    tbl[3] = '{0, 8'hFF, 11'd1, 4'd0, 4'd15, 8'hFF, 12'hFF0, 11'd1, 16'hFFFF};
    tbl[4] = '{1, 8'h40, 11'd4, 4'd7, 4'd2, 8'h00, 12'h400, 11'd4, 16'hFFFF};
    tbl[5] = '{0, 8'h3A, 11'd2, 4'd15, 4'd0, 8'h5A, 12'h3A0, 11'd2, 16'h8000};
    repeat (2) step();
    chk("rst_ready", op_ready_o, 1);
    chk("rst_write", amm_write_o, 0);
    chk("rst_read", amm_read_o, 0);
    chk("rst_addr", amm_address_o, 0);
    chk("rst_be", amm_byteenable_o, 0);
    chk("rst_wr_cnt", wr_burst_cnt_o, 0);
    chk("rst_rd_cnt", rd_burst_cnt_o, 0);
    rst_i = 1'b0;
    step();
    foreach (tbl[k]) begin
      wait_ready();
      drive(tbl[k].typ, tbl[k].addr, tbl[k].n, tbl[k].s, tbl[k].e, tbl[k].pat);
      step();
      op_valid_i = 1'b0;
      chk("vec_addr", amm_address_o, tbl[k].ea);
      chk("vec_burstcount", amm_burstcount_o, tbl[k].ebc);
      chk("vec_be", amm_byteenable_o, tbl[k].ebe);
      chk("vec_write", amm_write_o, !tbl[k].typ);
      chk("vec_read", amm_read_o, tbl[k].typ);
      if (!tbl[k].typ) chk("vec_wdata", amm_writedata_o, {16{tbl[k].pat}});
      g = 0;
      while (!op_ready_o && g < 40) begin step(); g++; end
      chk("vec_done", op_ready_o, 1);
      if (tbl[k].typ) exp_rd++; else exp_wr++;
      chk("vec_wr_cnt", wr_burst_cnt_o, 32'(exp_wr));
      chk("vec_rd_cnt", rd_burst_cnt_o, 32'(exp_rd));
    end
    run_op(0, 8'h09, 11'd3, 4'd4, 4'd1, 8'hC3, 0, 1, 2, hi);
    chk("t2_write_cycles", hi, 5);
    run_op(1, 8'h40, 11'd4, 4'd0, 4'd0, 8'h00, 0, 0, 3, hi);
    chk("t3_read_cycles", hi, 4);
    wait_ready();
    drive(0, 8'h21, 11'd2, 4'd1, 4'd14, 8'h11);
    step();
    chk("t4_addr_a", amm_address_o, 12'h210);
    drive(0, 8'h33, 11'd1, 4'd0, 4'd3, 8'h22);
    chk("t4_be_a0", amm_byteenable_o, model_be(0, 2, 1, 14));
    step();
    chk("t4_be_a1", amm_byteenable_o, model_be(1, 2, 1, 14));
    chk("t4_addr_a_held", amm_address_o, 12'h210);
    chk("t4_wdata_a_held", amm_writedata_o, {16{8'h11}});
    step();
    chk("t4_gap_write", amm_write_o, 0);
    chk("t4_gap_ready", op_ready_o, 1);
    step();
    op_valid_i = 1'b0;
    chk("t4_b_write", amm_write_o, 1);
    chk("t4_b_addr", amm_address_o, 12'h330);
    chk("t4_b_be", amm_byteenable_o, model_be(0, 1, 0, 3));
    chk("t4_b_wdata", amm_writedata_o, {16{8'h22}});
    step();
    exp_wr += 2;
    chk("t4_b_done", amm_write_o, 0);
    chk("t4_wr_cnt", wr_burst_cnt_o, 32'(exp_wr));
    repeat (30)
      run_op(1'($urandom), 8'($urandom), 11'($urandom_range(0, 6)), 4'($urandom),
             4'($urandom), 8'($urandom), 1, 0, 0, dummy);
    wait_ready();
    drive(0, 8'h60, 11'd8, 4'd0, 4'd15, 8'h77);
    step();
    op_valid_i = 1'b0;
    step();
    step();
    chk("t5_beat2_write", amm_write_o, 1);
    rst_i = 1'b1;
    step();
    exp_wr = 0; exp_rd = 0;
    chk("t5_write", amm_write_o, 0);
    chk("t5_ready", op_ready_o, 1);
    chk("t5_wr_cnt", wr_burst_cnt_o, 32'(exp_wr));
    chk("t5_rd_cnt", rd_burst_cnt_o, 32'(exp_rd));
    chk("t5_addr", amm_address_o, 0);
    rst_i = 1'b0;
    repeat (3) begin
      step();
      chk("t5_no_beats", amm_write_o, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
